// File: rtl/nn_pkg.sv
// Shared definitions for the MNIST accelerator datapath stages.
// FP32 field layout, argmax key helper and sequencer state codes.
package nn_pkg;

    localparam int         FP_SIGN_BIT = 31;
    localparam int         FP_EXP_HI   = 30;
    localparam int         FP_EXP_LO   = 23;
    localparam int         FP_MANT_HI  = 22;
    localparam logic [7:0] EXP_MAX     = 8'hFF;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD    = 3'd1;
    localparam logic [2:0] S_FEED    = 3'd2;
    localparam logic [2:0] S_COLLECT = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    // Ordering key: negatives and NaNs sink to zero, the rest
    // compare correctly as unsigned magnitude bits.
    function automatic logic [30:0] fp32_mag_key(input logic [31:0] x);
        logic is_nan;
        is_nan = (x[FP_EXP_HI:FP_EXP_LO] == EXP_MAX)
              && (x[FP_MANT_HI:0] != '0);
        if (x[FP_SIGN_BIT] || is_nan)
            return '0;
        return x[FP_EXP_HI:0];
    endfunction

endpackage

// File: rtl/fp32_argmax_tracker.sv
// Running argmax over a stream of FP32 beats.
// Strictly-greater update keeps the lowest index on ties.
module fp32_argmax_tracker #(
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             valid,
    input  logic [31:0]      data,
    input  logic [IDX_W-1:0] idx,
    output logic [IDX_W-1:0] max_idx,
    output logic [31:0]      max_val
);
    import nn_pkg::*;

    logic        have;
    logic [30:0] max_key;
    logic [30:0] key;

    assign key = fp32_mag_key(data);

    // First beat after clear always loads; later beats only if larger.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            have    <= 1'b0;
            max_key <= '0;
            max_idx <= '0;
            max_val <= '0;
        end else if (clr) begin
            have    <= 1'b0;
            max_key <= '0;
            max_idx <= '0;
            max_val <= '0;
        end else if (valid && (!have || key > max_key)) begin
            have    <= 1'b1;
            max_key <= key;
            max_idx <= idx;
            max_val <= data;
        end
    end

endmodule

// File: rtl/softmax_seq_ctrl.sv
// Sequencer between the output dense layer and the serial softmax.
// Buffers logits, streams them out, collects probabilities, argmax.
module softmax_seq_ctrl #(
    parameter int N       = 10,
    parameter int IDX_W   = $clog2(N),
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             logit_valid,
    output logic             logit_ready,
    input  logic [31:0]      logit_data,
    output logic             sm_clr,
    output logic             sm_valid_in,
    output logic [31:0]      sm_data_in,
    input  logic             sm_valid_out,
    input  logic [31:0]      sm_data_out,
    output logic             busy,
    output logic             done,
    output logic [IDX_W-1:0] class_idx,
    output logic [31:0]      class_prob,
    output logic             timeout_err,
    input  logic [IDX_W-1:0] rd_addr,
    output logic [31:0]      rd_data
);
    import nn_pkg::*;

    localparam int                WAIT_W    = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W-1:0]  LAST      = IDX_W'(N - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [IDX_W:0]    N_EXT     = (IDX_W + 1)'(N);

    logic [2:0]        state;
    logic [IDX_W-1:0]  cnt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [31:0]       logit_buf [N];
    logic [31:0]       prob_buf  [N];
    logic              accept;
    logic              load_hs;
    logic              beat;

    assign accept      = (state == S_IDLE) && start;
    assign logit_ready = (state == S_LOAD);
    assign load_hs     = logit_valid && logit_ready;
    assign beat        = (state == S_COLLECT) && sm_valid_out;
    assign sm_valid_in = (state == S_FEED);
    assign sm_data_in  = sm_valid_in ? logit_buf[cnt] : '0;
    assign busy        = (state != S_IDLE);
    assign done        = (state == S_DONE);

    // Control FSM; cnt is the logit, feed and probability index in turn.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            wait_cnt    <= '0;
            sm_clr      <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            sm_clr <= accept;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        state       <= S_LOAD;
                        cnt         <= '0;
                        timeout_err <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (load_hs) begin
                        if (cnt == LAST) begin
                            cnt   <= '0;
                            state <= S_FEED;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                S_FEED: begin
                    if (cnt == LAST) begin
                        cnt      <= '0;
                        wait_cnt <= '0;
                        state    <= S_COLLECT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_COLLECT: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    if (beat)
                        cnt <= cnt + 1'b1;
                    if (beat && cnt == LAST) begin
                        state <= S_DONE;
                    end else if (wait_cnt == WAIT_LAST) begin
                        timeout_err <= 1'b1;
                        state       <= S_DONE;
                    end
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Logit capture during LOAD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++)
                logit_buf[i] <= '0;
        end else if (load_hs) begin
            logit_buf[cnt] <= logit_data;
        end
    end

    // Probability capture; wiped on a new inference so gaps read 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++)
                prob_buf[i] <= '0;
        end else if (accept) begin
            for (int i = 0; i < N; i++)
                prob_buf[i] <= '0;
        end else if (beat) begin
            prob_buf[cnt] <= sm_data_out;
        end
    end

    // Registered read port; addresses past the last class read 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rd_data <= '0;
        else if ({1'b0, rd_addr} < N_EXT)
            rd_data <= prob_buf[rd_addr];
        else
            rd_data <= '0;
    end

    fp32_argmax_tracker #(
        .IDX_W (IDX_W)
    ) u_argmax (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (accept),
        .valid   (beat),
        .data    (sm_data_out),
        .idx     (cnt),
        .max_idx (class_idx),
        .max_val (class_prob)
    );

endmodule

// File: tb/tb_softmax_seq_ctrl.sv
// Self-checking bench for softmax_seq_ctrl (N=4, TIMEOUT=32).
// Directed and random inferences against a behavioural argmax model.
`timescale 1ns/1ps
module tb_softmax_seq_ctrl;

    localparam int N     = 4;
    localparam int IDX_W = 2;
    localparam int TO    = 32;
    localparam int SMLAT = 5;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             logit_valid = 1'b0;
    logic [31:0]      logit_data = '0;
    logic             sm_valid_out = 1'b0;
    logic [31:0]      sm_data_out = '0;
    logic [IDX_W-1:0] rd_addr = '0;
    logic             logit_ready;
    logic             sm_clr;
    logic             sm_valid_in;
    logic [31:0]      sm_data_in;
    logic             busy;
    logic             done;
    logic [IDX_W-1:0] class_idx;
    logic [31:0]      class_prob;
    logic             timeout_err;
    logic [31:0]      rd_data;

    int errors = 0;
    int checks = 0;
    int clr_cnt = 0;
    int done_cnt = 0;
    logic [31:0] logit_v [N];
    logic [31:0] prob_v  [N];
    logic [31:0] g_idx;
    logic [31:0] g_val;

    softmax_seq_ctrl #(
        .N       (N),
        .IDX_W   (IDX_W),
        .TIMEOUT (TO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .logit_valid  (logit_valid),
        .logit_ready  (logit_ready),
        .logit_data   (logit_data),
        .sm_clr       (sm_clr),
        .sm_valid_in  (sm_valid_in),
        .sm_data_in   (sm_data_in),
        .sm_valid_out (sm_valid_out),
        .sm_data_out  (sm_data_out),
        .busy         (busy),
        .done         (done),
        .class_idx    (class_idx),
        .class_prob   (class_prob),
        .timeout_err  (timeout_err),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (sm_clr) clr_cnt <= clr_cnt + 1;
        if (done)   done_cnt <= done_cnt + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Highest non-negative, non-NaN value; first occurrence wins.
    function automatic void ref_argmax(input int n,
                                       output logic [31:0] idx,
                                       output logic [31:0] val);
        longint best;
        longint key;
        logic [31:0] p;
        bit bad;
        best = -1;
        idx = 0;
        val = 0;
        for (int i = 0; i < n; i++) begin
            p = prob_v[i];
            bad = p[31] || (p[30:23] == 8'hFF && p[22:0] != 0);
            key = bad ? 0 : longint'(p[30:0]);
            if (key > best) begin
                best = key;
                idx = i;
                val = p;
            end
        end
    endfunction

    task automatic do_inf(input int nresp, input bit stall,
                          input bit hold, input string nm);
        int c0;
        int d0;
        int dj;
        int exp_j;
        c0 = clr_cnt;
        d0 = done_cnt;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        if (!hold) start = 1'b0;
        chk($sformatf("%s.clr", nm), 32'(sm_clr), 1);
        chk($sformatf("%s.busy", nm), 32'(busy), 1);
        chk($sformatf("%s.to_clr", nm), 32'(timeout_err), 0);
        chk($sformatf("%s.prob_clr", nm), class_prob, 0);
        for (int i = 0; i < N; i++) begin
            if (stall && i > 0) begin
                logit_valid = 1'b0;
                logit_data = $urandom;
                repeat (2) @(negedge clk);
            end
            logit_valid = 1'b1;
            logit_data = logit_v[i];
            @(negedge clk);
        end
        logit_valid = 1'b0;
        logit_data = $urandom;
        for (int i = 0; i < N; i++) begin
            chk($sformatf("%s.feed_v%0d", nm, i), 32'(sm_valid_in), 1);
            chk($sformatf("%s.feed_d%0d", nm, i), sm_data_in, logit_v[i]);
            @(negedge clk);
        end
        chk($sformatf("%s.feed_end", nm), 32'(sm_valid_in), 0);
        dj = -1;
        for (int j = 0; j < 60; j++) begin
            if (done) begin
                dj = j;
                break;
            end
            if (j >= SMLAT && j < SMLAT + nresp) begin
                sm_valid_out = 1'b1;
                sm_data_out = prob_v[j - SMLAT];
            end else begin
                sm_valid_out = 1'b0;
                sm_data_out = $urandom;
            end
            @(negedge clk);
        end
        exp_j = (nresp == N) ? SMLAT + N : TO;
        chk($sformatf("%s.done_at", nm), 32'(dj), 32'(exp_j));
        ref_argmax(nresp, g_idx, g_val);
        chk($sformatf("%s.idx", nm), 32'(class_idx), g_idx);
        chk($sformatf("%s.prob", nm), class_prob, g_val);
        chk($sformatf("%s.to_err", nm), 32'(timeout_err),
            32'(nresp < N));
        // surplus beat while in DONE must be ignored
        sm_valid_out = 1'b1;
        sm_data_out = 32'h7F000000;
        start = 1'b0;
        @(negedge clk);
        sm_valid_out = 1'b0;
        chk($sformatf("%s.done_low", nm), 32'(done), 0);
        chk($sformatf("%s.idle", nm), 32'(busy), 0);
        chk($sformatf("%s.done_cnt", nm), 32'(done_cnt - d0), 1);
        chk($sformatf("%s.clr_cnt", nm), 32'(clr_cnt - c0), 1);
        chk($sformatf("%s.idx_hold", nm), 32'(class_idx), g_idx);
        chk($sformatf("%s.prob_hold", nm), class_prob, g_val);
        for (int a = 0; a < N; a++) begin
            rd_addr = IDX_W'(a);
            @(negedge clk);
            chk($sformatf("%s.rd%0d", nm, a), rd_data,
                (a < nresp) ? prob_v[a] : 32'h0);
        end
    endtask

    initial begin
        int d0;
        #12;
        chk("rst.busy", 32'(busy), 0);
        chk("rst.done", 32'(done), 0);
        chk("rst.ready", 32'(logit_ready), 0);
        chk("rst.smv", 32'(sm_valid_in), 0);
        chk("rst.clr", 32'(sm_clr), 0);
        chk("rst.idx", 32'(class_idx), 0);
        chk("rst.prob", class_prob, 0);
        chk("rst.to", 32'(timeout_err), 0);
        chk("rst.rd", rd_data, 0);
        @(negedge clk);
        rst_n = 1'b1;

        logit_v = '{32'hBF99999A, 32'h3F000000, 32'h40000000, 32'h404CCCCD};
        prob_v  = '{32'h3C23D70A, 32'h3D4CCCCD, 32'h3E4CCCCD, 32'h3F333333};
        do_inf(N, 1'b0, 1'b0, "normal");
        chk("normal.idx3", 32'(class_idx), 3);
        chk("normal.p3", class_prob, 32'h3F333333);

        prob_v = '{32'h3E800000, 32'h7FC00000, 32'h3E800000, 32'hBE800000};
        do_inf(N, 1'b0, 1'b0, "tie");
        chk("tie.idx0", 32'(class_idx), 0);
        chk("tie.p", class_prob, 32'h3E800000);

        for (int i = 0; i < N; i++) begin
            logit_v[i] = $urandom;
            prob_v[i] = $urandom;
        end
        prob_v[3] = prob_v[1];
        do_inf(N, 1'b1, 1'b0, "stall");

        for (int i = 0; i < N; i++) begin
            logit_v[i] = $urandom;
            prob_v[i] = {1'b0, 31'($urandom)};
        end
        do_inf(2, 1'b0, 1'b0, "timeout");

        for (int i = 0; i < N; i++) begin
            logit_v[i] = $urandom;
            prob_v[i] = {1'b0, 31'($urandom)};
        end
        do_inf(N, 1'b0, 1'b0, "after_to");

        // reset during the third feed beat
        rd_addr = '0;
        for (int i = 0; i < N; i++)
            logit_v[i] = $urandom;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < N; i++) begin
            logit_valid = 1'b1;
            logit_data = logit_v[i];
            @(negedge clk);
        end
        logit_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("rstf.in_feed", 32'(sm_valid_in), 1);
        d0 = done_cnt;
        rst_n = 1'b0;
        #1;
        chk("rstf.busy", 32'(busy), 0);
        chk("rstf.smv", 32'(sm_valid_in), 0);
        chk("rstf.smd", sm_data_in, 0);
        chk("rstf.idx", 32'(class_idx), 0);
        chk("rstf.prob", class_prob, 0);
        chk("rstf.rd", rd_data, 0);
        repeat (3) @(negedge clk);
        chk("rstf.nodone", 32'(done_cnt - d0), 0);
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) begin
            logit_v[i] = $urandom;
            prob_v[i] = $urandom;
        end
        do_inf(N, 1'b0, 1'b0, "post_rst");

        // start held high across a whole inference, then idle noise
        for (int i = 0; i < N; i++) begin
            logit_v[i] = $urandom;
            prob_v[i] = {1'b0, 31'($urandom)};
        end
        do_inf(N, 1'b1, 1'b1, "hold");
        d0 = clr_cnt;
        for (int i = 0; i < 3; i++) begin
            sm_valid_out = 1'b1;
            sm_data_out = 32'h7F7FFFFF;
            @(negedge clk);
        end
        sm_valid_out = 1'b0;
        @(negedge clk);
        chk("noise.busy", 32'(busy), 0);
        chk("noise.clr", 32'(clr_cnt - d0), 0);
        chk("noise.idx", 32'(class_idx), g_idx);
        chk("noise.prob", class_prob, g_val);
        rd_addr = 2'd1;
        @(negedge clk);
        chk("noise.rd1", rd_data, prob_v[1]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
